// File: rtl/dma_priority_arbiter.sv
// rtl/dma_priority_arbiter.sv - channel priority arbiter for an 8237A-style DMA controller
//
// Samples the four DREQ pins and merges them with the software request register.
// It applies the mask and the command-register polarity, disable and priority-mode
// bits, then locks a single channel as the granted channel until the timing FSM
// reports the end of service.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        synchronous active-high reset
//   DREQ         raw channel request pins
//   dreqSense    0 = DREQ active high, 1 = DREQ active low
//   dackSense    0 = DACK active low, 1 = DACK active high
//   rotating     0 = fixed priority (ch0 highest), 1 = rotating priority
//   ctrlDisable  blocks new grants
//   maskReg      per-channel hardware request mask (1 = ignored)
//   swReqWr      one-cycle write strobe for the software request register
//   swReqData    [2] = set/clear value, [1:0] = channel
//   validDACK    acknowledge window from the timing FSM
//   cycleDone    end-of-service pulse from the timing FSM
//   eopDone      terminal count / external EOP on the granted channel
//   VALID_DREQ   one-hot granted request, 0 when idle
//   chSel        granted channel index, holds its value when idle
//   busy         a grant is active
//   DACK         acknowledge pins, polarity per dackSense
//   reqStatus    registered pending-request bits (status register [7:4])

module dma_priority_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqSense,
  input  logic              dackSense,
  input  logic              rotating,
  input  logic              ctrlDisable,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              swReqWr,
  input  logic [2:0]        swReqData,
  input  logic              validDACK,
  input  logic              cycleDone,
  input  logic              eopDone,
  output logic [NUM_CH-1:0] VALID_DREQ,
  output logic [1:0]        chSel,
  output logic              busy,
  output logic [NUM_CH-1:0] DACK,
  output logic [NUM_CH-1:0] reqStatus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] dreqQ;
  logic [NUM_CH-1:0] swReq;
  logic [1:0]        lowPri;
  logic [NUM_CH-1:0] elig;

  logic [1:0]        start;
  logic [1:0]        idx;
  logic [1:0]        winner;
  logic              found;

  logic [NUM_CH-1:0] swSetMask;
  logic [NUM_CH-1:0] swClrMask;

  // Input sync stage with polarity normalisation: dreqQ is always active high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dreqQ <= '0;
    end else begin
      dreqQ <= DREQ ^ {NUM_CH{dreqSense}};
    end
  end

  // Software request register. The EOP clear is applied after the write so a
  // write and a clear landing on the same bit leave it cleared.
  always_comb begin
    swSetMask = '0;
    swClrMask = '0;
    if (swReqWr) begin
      swSetMask[swReqData[1:0]] = 1'b1;
    end
    if (eopDone) begin
      swClrMask[chSel] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      swReq <= '0;
    end else begin
      if (swReqWr) begin
        swReq <= ((swReq & ~swSetMask) | (swReqData[2] ? swSetMask : '0)) & ~swClrMask;
      end else begin
        swReq <= swReq & ~swClrMask;
      end
    end
  end

  // Software requests bypass the mask.
  assign elig = (dreqQ & ~maskReg) | swReq;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      reqStatus <= '0;
    end else begin
      reqStatus <= elig;
    end
  end

  // Priority search. Fixed mode always starts at ch0; rotating mode starts one
  // above the last serviced channel and wraps. With lowPri at its reset value
  // of 3 both modes give the same order.
  always_comb begin
    start  = rotating ? (lowPri + 2'd1) : 2'd0;
    idx    = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = start + 2'(i);
      if (!found && elig[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Grant FSM. Once in GRANT, chSel and VALID_DREQ are frozen until cycleDone,
  // regardless of request, mask or disable changes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      VALID_DREQ <= '0;
      chSel      <= '0;
      lowPri     <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (found && !ctrlDisable) begin
            state      <= GRANT;
            chSel      <= winner;
            VALID_DREQ <= NUM_CH'(1) << winner;
          end
        end
        GRANT: begin
          if (cycleDone) begin
            state      <= IDLE;
            VALID_DREQ <= '0;
            if (rotating) begin
              lowPri <= chSel;
            end
          end
        end
        default: begin
          state      <= IDLE;
          VALID_DREQ <= '0;
        end
      endcase
    end
  end

  assign busy = (state == GRANT);

  // Acknowledge is driven only inside the timing FSM's window, then inverted
  // when the pins are active low.
  always_comb begin
    DACK = '0;
    if (validDACK && busy) begin
      DACK = NUM_CH'(1) << chSel;
    end
    DACK = DACK ^ {NUM_CH{~dackSense}};
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb/tb_dma_priority_arbiter.sv - directed self-checking bench for dma_priority_arbiter

module tb_dma_priority_arbiter;

  logic       CLK;
  logic       RESET;
  logic [3:0] DREQ;
  logic       dreqSense;
  logic       dackSense;
  logic       rotating;
  logic       ctrlDisable;
  logic [3:0] maskReg;
  logic       swReqWr;
  logic [2:0] swReqData;
  logic       validDACK;
  logic       cycleDone;
  logic       eopDone;
  logic [3:0] VALID_DREQ;
  logic [1:0] chSel;
  logic       busy;
  logic [3:0] DACK;
  logic [3:0] reqStatus;

  int total;
  int bad;

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DREQ       (DREQ),
    .dreqSense  (dreqSense),
    .dackSense  (dackSense),
    .rotating   (rotating),
    .ctrlDisable(ctrlDisable),
    .maskReg    (maskReg),
    .swReqWr    (swReqWr),
    .swReqData  (swReqData),
    .validDACK  (validDACK),
    .cycleDone  (cycleDone),
    .eopDone    (eopDone),
    .VALID_DREQ (VALID_DREQ),
    .chSel      (chSel),
    .busy       (busy),
    .DACK       (DACK),
    .reqStatus  (reqStatus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_cycle_done();
    cycleDone = 1'b1;
    tick();
    cycleDone = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    RESET       = 1'b1;
    DREQ        = 4'b0000;
    dreqSense   = 1'b0;
    dackSense   = 1'b0;
    rotating    = 1'b0;
    ctrlDisable = 1'b0;
    maskReg     = 4'b0000;
    swReqWr     = 1'b0;
    swReqData   = 3'b000;
    validDACK   = 1'b0;
    cycleDone   = 1'b0;
    eopDone     = 1'b0;
    tick();
    tick();
    RESET = 1'b0;

    // Reset state
    check("rst_valid", VALID_DREQ, 4'b0000);
    check("rst_chsel", chSel, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_dack", DACK, 4'hF);
    check("rst_status", reqStatus, 4'b0000);

    // Fixed priority, two-cycle latency from the pin
    DREQ = 4'b1010;
    tick();
    check("fix_lat1", VALID_DREQ, 4'b0000);
    tick();
    check("fix_valid", VALID_DREQ, 4'b0010);
    check("fix_chsel", chSel, 2'd1);
    check("fix_busy", busy, 1'b1);
    check("fix_status", reqStatus, 4'b1010);
    pulse_cycle_done();
    check("fix_idle", busy, 1'b0);
    tick();
    check("fix_regrant", VALID_DREQ, 4'b0010);
    DREQ = 4'b0000;
    pulse_cycle_done();
    tick();
    check("fix_quiet", busy, 1'b0);

    // Rotating priority, all channels requesting
    rotating = 1'b1;
    DREQ     = 4'b1111;
    tick();
    tick();
    check("rot_g0", chSel, 2'd0);
    pulse_cycle_done();
    tick();
    check("rot_g1", chSel, 2'd1);
    pulse_cycle_done();
    tick();
    check("rot_g2", chSel, 2'd2);
    pulse_cycle_done();
    tick();
    check("rot_g3", chSel, 2'd3);
    pulse_cycle_done();
    tick();
    check("rot_g4", chSel, 2'd0);
    check("rot_g4_valid", VALID_DREQ, 4'b0001);
    DREQ = 4'b0000;
    pulse_cycle_done();
    rotating = 1'b0;
    tick();

    // Mask and active-low sense
    dreqSense = 1'b1;
    DREQ      = 4'b1110;
    maskReg   = 4'b0001;
    tick();
    tick();
    check("mask_nogrant", VALID_DREQ, 4'b0000);
    check("mask_status", reqStatus, 4'b0000);
    maskReg = 4'b0000;
    tick();
    check("sense_grant", VALID_DREQ, 4'b0001);
    check("sense_chsel", chSel, 2'd0);
    dreqSense = 1'b0;
    DREQ      = 4'b0000;
    pulse_cycle_done();
    tick();

    // Software request set, EOP clear
    swReqWr   = 1'b1;
    swReqData = 3'b110;
    tick();
    swReqWr = 1'b0;
    check("sw_lat", busy, 1'b0);
    tick();
    check("sw_valid", VALID_DREQ, 4'b0100);
    check("sw_chsel", chSel, 2'd2);
    check("sw_status", reqStatus, 4'b0100);
    eopDone = 1'b1;
    tick();
    eopDone = 1'b0;
    check("eop_no_exit", busy, 1'b1);
    pulse_cycle_done();
    check("sw_idle", busy, 1'b0);
    tick();
    check("sw_cleared_status", reqStatus, 4'b0000);
    check("sw_cleared_nogrant", busy, 1'b0);

    // Set and clear on the same bit in the same cycle: clear wins (chSel holds 2)
    swReqWr   = 1'b1;
    swReqData = 3'b110;
    eopDone   = 1'b1;
    tick();
    swReqWr = 1'b0;
    eopDone = 1'b0;
    tick();
    check("setclr_status", reqStatus, 4'b0000);
    check("setclr_busy", busy, 1'b0);

    // Grant lock and DACK
    DREQ = 4'b1000;
    tick();
    tick();
    check("lock_grant", chSel, 2'd3);
    DREQ        = 4'b0001;
    ctrlDisable = 1'b1;
    tick();
    tick();
    check("lock_chsel", chSel, 2'd3);
    check("lock_valid", VALID_DREQ, 4'b1000);
    validDACK = 1'b1;
    #1;
    check("dack_low", DACK, 4'b0111);
    dackSense = 1'b1;
    #1;
    check("dack_high", DACK, 4'b1000);
    validDACK = 1'b0;
    #1;
    check("dack_high_idle", DACK, 4'b0000);
    dackSense = 1'b0;
    pulse_cycle_done();
    tick();
    tick();
    check("disable_block", busy, 1'b0);
    ctrlDisable = 1'b0;
    tick();
    check("disable_release", VALID_DREQ, 4'b0001);

    // Reset mid-service
    validDACK = 1'b1;
    RESET     = 1'b1;
    tick();
    check("mrst_valid", VALID_DREQ, 4'b0000);
    check("mrst_busy", busy, 1'b0);
    check("mrst_dack", DACK, 4'hF);
    RESET = 1'b0;
    tick();
    check("mrst_wait", busy, 1'b0);
    tick();
    check("mrst_regrant", VALID_DREQ, 4'b0001);
    check("mrst_dack_win", DACK, 4'b1110);
    validDACK = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
